// File: rtl/audio_stream_ctrl.sv
// audio_stream_ctrl: flash word fetcher and lane serializer for the audio path.
// Each fetched word is split into LANES samples that are played one per tick,
// in forward or reverse order, under keyboard play/stop/direction/restart control.
// Optional build macro: AUDIO_STREAM_LOOP_EN (continue playing after a track wrap
// instead of pausing).
module audio_stream_ctrl #(
   parameter int unsigned       DATA_W      = 32,
   parameter int unsigned       LANE_W      = 16,
   parameter int unsigned       OUT_W       = 8,
   parameter int unsigned       ADDR_W      = 23,
   parameter logic [ADDR_W-1:0] ADDR_START  = '0,
   parameter logic [ADDR_W-1:0] ADDR_END    = ADDR_W'(23'h7FFFF),
   parameter logic [7:0]        KEY_PLAY    = 8'h24,
   parameter logic [7:0]        KEY_STOP    = 8'h23,
   parameter logic [7:0]        KEY_FWD     = 8'h2B,
   parameter logic [7:0]        KEY_BACK    = 8'h32,
   parameter logic [7:0]        KEY_RESTART = 8'h2D
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [7:0]        kbd_data,
   input  logic              kbd_ready,
   input  logic              tick,
   output logic              read_start,
   output logic [ADDR_W-1:0] read_addr,
   input  logic              read_valid,
   input  logic [DATA_W-1:0] read_data,
   output logic [OUT_W-1:0]  audio_out,
   output logic              sample_valid,
   output logic              playing,
   output logic              back_mode,
   output logic              underrun,
   output logic              end_of_track
);

   localparam int unsigned LANES   = DATA_W / LANE_W;
   localparam int unsigned LANE_IW = (LANES > 1) ? $clog2(LANES) : 1;
   localparam logic [LANE_IW-1:0] LANE_LAST = LANE_IW'(LANES - 1);

   typedef enum logic [1:0] {
      S_PAUSE,
      S_FETCH,
      S_WAIT_DATA,
      S_WAIT_TICK
   } state_t;

   state_t state_q, state_nxt;

   logic [ADDR_W-1:0] addr_q, addr_nxt;
   logic [LANE_IW-1:0] lane_q, lane_nxt;
   logic [DATA_W-1:0] word_q, word_nxt;
   logic              dir_q, dir_nxt;          // lane order of the word in progress
   logic              back_q, back_nxt;        // direction selected by the keys
   logic              resume_q, resume_nxt;    // next latch keeps lane and order
   logic              stop_pend_q, stop_pend_nxt;
   logic              rstrt_pend_q, rstrt_pend_nxt;
   logic [OUT_W-1:0]  audio_q, audio_nxt;
   logic              sv_q, sv_nxt;
   logic              rs_q, rs_nxt;
   logic              ur_q, ur_nxt;
   logic              eot_q, eot_nxt;
   logic              play_q, play_nxt;

   logic              key_play_c, key_stop_c, key_fwd_c, key_back_c, key_restart_c;
   logic [OUT_W-1:0]  sample_c;
   logic [ADDR_W-1:0] restart_addr_c, step_addr_c;
   logic              wrap_c, last_lane_c, stop_now_c, rstrt_now_c;
   logic              unused_word_c;

   assign read_start   = rs_q;
   assign read_addr    = addr_q;
   assign audio_out    = audio_q;
   assign sample_valid = sv_q;
   assign playing      = play_q;
   assign back_mode    = back_q;
   assign underrun     = ur_q;
   assign end_of_track = eot_q;

   // Only the top OUT_W bits of each lane reach the output.
   assign unused_word_c = ^word_q;

   // Key decode, sample select and address stepping.
   always_comb begin
      key_play_c    = kbd_ready && (kbd_data == KEY_PLAY);
      key_stop_c    = kbd_ready && (kbd_data == KEY_STOP);
      key_fwd_c     = kbd_ready && (kbd_data == KEY_FWD);
      key_back_c    = kbd_ready && (kbd_data == KEY_BACK);
      key_restart_c = kbd_ready && (kbd_data == KEY_RESTART);

      sample_c = OUT_W'(word_q >> (int'(lane_q) * int'(LANE_W) + int'(LANE_W - OUT_W)));

      restart_addr_c = back_q ? ADDR_END : ADDR_START;
      if (back_q) begin
         wrap_c      = (addr_q == ADDR_START);
         step_addr_c = wrap_c ? ADDR_END : addr_q - ADDR_W'(1);
      end else begin
         wrap_c      = (addr_q == ADDR_END);
         step_addr_c = wrap_c ? ADDR_START : addr_q + ADDR_W'(1);
      end
      last_lane_c = dir_q ? (lane_q == '0) : (lane_q == LANE_LAST);

      stop_now_c  = stop_pend_q || key_stop_c;
      rstrt_now_c = rstrt_pend_q || (key_restart_c && !key_stop_c);
   end

   // Next-state and datapath update.
   always_comb begin
      state_nxt      = state_q;
      addr_nxt       = addr_q;
      lane_nxt       = lane_q;
      word_nxt       = word_q;
      dir_nxt        = dir_q;
      resume_nxt     = resume_q;
      stop_pend_nxt  = stop_pend_q;
      rstrt_pend_nxt = rstrt_pend_q;
      audio_nxt      = audio_q;
      sv_nxt         = 1'b0;
      rs_nxt         = 1'b0;
      ur_nxt         = 1'b0;
      eot_nxt        = 1'b0;
      back_nxt       = back_q;

      if (key_fwd_c) begin
         back_nxt = 1'b0;
      end else if (key_back_c) begin
         back_nxt = 1'b1;
      end

      case (state_q)
         S_PAUSE: begin
            if (key_stop_c) begin
               state_nxt = S_PAUSE;
            end else if (key_restart_c) begin
               addr_nxt   = restart_addr_c;
               lane_nxt   = '0;
               resume_nxt = 1'b0;
            end else if (key_play_c) begin
               state_nxt = S_FETCH;
            end
         end

         S_FETCH: begin
            ur_nxt = tick;
            if (key_stop_c) begin
               state_nxt = S_PAUSE;
            end else if (key_restart_c) begin
               addr_nxt   = restart_addr_c;
               lane_nxt   = '0;
               resume_nxt = 1'b0;
            end else begin
               rs_nxt    = 1'b1;
               state_nxt = S_WAIT_DATA;
            end
         end

         S_WAIT_DATA: begin
            ur_nxt = tick;
            if (read_valid) begin
               stop_pend_nxt  = 1'b0;
               rstrt_pend_nxt = 1'b0;
               if (rstrt_now_c) begin
                  // Outstanding read completes; its data is discarded.
                  addr_nxt   = restart_addr_c;
                  lane_nxt   = '0;
                  resume_nxt = 1'b0;
                  state_nxt  = stop_now_c ? S_PAUSE : S_FETCH;
               end else begin
                  word_nxt = read_data;
                  if (!resume_q) begin
                     lane_nxt = back_q ? LANE_LAST : '0;
                     dir_nxt  = back_q;
                  end
                  resume_nxt = stop_now_c;
                  state_nxt  = stop_now_c ? S_PAUSE : S_WAIT_TICK;
               end
            end else begin
               stop_pend_nxt  = stop_now_c;
               rstrt_pend_nxt = rstrt_now_c;
            end
         end

         S_WAIT_TICK: begin
            if (key_stop_c) begin
               resume_nxt = 1'b1;
               state_nxt  = S_PAUSE;
            end else if (key_restart_c) begin
               addr_nxt   = restart_addr_c;
               lane_nxt   = '0;
               resume_nxt = 1'b0;
               state_nxt  = S_FETCH;
            end else if (tick) begin
               audio_nxt = sample_c;
               sv_nxt    = 1'b1;
               if (!last_lane_c) begin
                  lane_nxt = dir_q ? lane_q - LANE_IW'(1) : lane_q + LANE_IW'(1);
               end else begin
                  addr_nxt  = step_addr_c;
                  eot_nxt   = wrap_c;
                  state_nxt = S_FETCH;
`ifdef AUDIO_STREAM_LOOP_EN
`else
                  if (wrap_c) begin
                     lane_nxt  = '0;
                     state_nxt = S_PAUSE;
                  end
`endif
               end
            end
         end

         default: state_nxt = S_PAUSE;
      endcase

      play_nxt = (state_nxt != S_PAUSE);
   end

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_PAUSE;
      end else begin
         state_q <= state_nxt;
      end
   end

   // Datapath and output registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         addr_q       <= ADDR_START;
         lane_q       <= '0;
         word_q       <= '0;
         dir_q        <= 1'b0;
         back_q       <= 1'b0;
         resume_q     <= 1'b0;
         stop_pend_q  <= 1'b0;
         rstrt_pend_q <= 1'b0;
         audio_q      <= '0;
         sv_q         <= 1'b0;
         rs_q         <= 1'b0;
         ur_q         <= 1'b0;
         eot_q        <= 1'b0;
         play_q       <= 1'b0;
      end else begin
         addr_q       <= addr_nxt;
         lane_q       <= lane_nxt;
         word_q       <= word_nxt;
         dir_q        <= dir_nxt;
         back_q       <= back_nxt;
         resume_q     <= resume_nxt;
         stop_pend_q  <= stop_pend_nxt;
         rstrt_pend_q <= rstrt_pend_nxt;
         audio_q      <= audio_nxt;
         sv_q         <= sv_nxt;
         rs_q         <= rs_nxt;
         ur_q         <= ur_nxt;
         eot_q        <= eot_nxt;
         play_q       <= play_nxt;
      end
   end

endmodule

// File: tb/tb_audio_stream_ctrl.sv
// Directed bench for audio_stream_ctrl with a short track (ADDR_END = 3).
module tb_audio_stream_ctrl;

   localparam logic [7:0] K_PLAY = 8'h24;
   localparam logic [7:0] K_STOP = 8'h23;
   localparam logic [7:0] K_FWD  = 8'h2B;
   localparam logic [7:0] K_BACK = 8'h32;
   localparam logic [7:0] K_RST  = 8'h2D;
`ifdef AUDIO_STREAM_LOOP_EN
   localparam logic LOOP = 1'b1;
`else
   localparam logic LOOP = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [7:0]  kbd_data = '0;
   logic        kbd_ready = 1'b0;
   logic        tick = 1'b0;
   logic        read_start;
   logic [22:0] read_addr;
   logic        read_valid = 1'b0;
   logic [31:0] read_data = '0;
   logic [7:0]  audio_out;
   logic        sample_valid, playing, back_mode, underrun, end_of_track;

   int nchecks = 0;
   int nerrors = 0;

   always #5 clk = ~clk;

   audio_stream_ctrl #(.ADDR_END(23'd3)) dut (
      .clk(clk), .rst(rst), .kbd_data(kbd_data), .kbd_ready(kbd_ready), .tick(tick),
      .read_start(read_start), .read_addr(read_addr), .read_valid(read_valid),
      .read_data(read_data), .audio_out(audio_out), .sample_valid(sample_valid),
      .playing(playing), .back_mode(back_mode), .underrun(underrun),
      .end_of_track(end_of_track)
   );

   typedef struct {
      logic [7:0]  kd;
      logic        kr;
      logic        tk;
      logic        rv;
      logic [31:0] rd;
      logic        rs;
      logic [22:0] addr;
      logic [7:0]  aud;
      logic        sv;
      logic        pl;
      logic        bm;
      logic        ur;
      logic        eot;
   } vec_t;

   vec_t vq[$];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      nchecks++;
      if (act !== exp) begin
         nerrors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic step(input logic [7:0] kd, input logic kr, input logic tk,
                       input logic rv, input logic [31:0] rd);
      @(negedge clk);
      kbd_data = kd; kbd_ready = kr; tick = tk; read_valid = rv; read_data = rd;
      @(posedge clk);
      #1;
   endtask

   task automatic idle();            step(8'h00, 1'b0, 1'b0, 1'b0, 32'h0); endtask
   task automatic key(input logic [7:0] k); step(k, 1'b1, 1'b0, 1'b0, 32'h0); endtask
   task automatic tk();              step(8'h00, 1'b0, 1'b1, 1'b0, 32'h0); endtask
   task automatic rv(input logic [31:0] d); step(8'h00, 1'b0, 1'b0, 1'b1, d); endtask

   task automatic do_reset();
      @(negedge clk);
      kbd_data = '0; kbd_ready = 1'b0; tick = 1'b0; read_valid = 1'b0; read_data = '0;
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      // kd, kr, tk, rv, rd, | rs, addr, aud, sv, pl, bm, ur, eot
      vq.push_back('{8'h00 , 1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 23'd0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
      vq.push_back('{K_PLAY, 1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 23'd0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0});
      vq.push_back('{8'h00 , 1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 23'd0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0});
      vq.push_back('{8'h00 , 1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 23'd0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0});
      vq.push_back('{8'h00 , 1'b0, 1'b0, 1'b1, 32'hAABBCCDD, 1'b0, 23'd0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0});
      vq.push_back('{8'h00 , 1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 23'd0, 8'hCC, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0});
      vq.push_back('{8'h00 , 1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 23'd0, 8'hCC, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0});
      vq.push_back('{8'h00 , 1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 23'd1, 8'hAA, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0});
      vq.push_back('{8'h00 , 1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 23'd1, 8'hAA, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0});
      vq.push_back('{K_BACK, 1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 23'd1, 8'hAA, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0});
      vq.push_back('{8'h00 , 1'b0, 1'b0, 1'b1, 32'h11223344, 1'b0, 23'd1, 8'hAA, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0});
      vq.push_back('{8'h00 , 1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 23'd1, 8'h11, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0});
      vq.push_back('{8'h00 , 1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 23'd0, 8'h33, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0});
      vq.push_back('{8'h00 , 1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 23'd0, 8'h33, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0});
      vq.push_back('{8'h00 , 1'b0, 1'b0, 1'b1, 32'h55667788, 1'b0, 23'd0, 8'h33, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0});
      vq.push_back('{8'h00 , 1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 23'd0, 8'h55, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0});
      vq.push_back('{8'h00 , 1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 23'd3, 8'h77, 1'b1, LOOP, 1'b1, 1'b0, 1'b1});
      vq.push_back('{8'h00 , 1'b0, 1'b0, 1'b0, 32'h0,        LOOP, 23'd3, 8'h77, 1'b0, LOOP, 1'b1, 1'b0, 1'b0});

      do_reset();
      foreach (vq[i]) begin
         step(vq[i].kd, vq[i].kr, vq[i].tk, vq[i].rv, vq[i].rd);
         chk($sformatf("v%0d read_start", i),   32'(read_start),   32'(vq[i].rs));
         chk($sformatf("v%0d read_addr", i),    32'(read_addr),    32'(vq[i].addr));
         chk($sformatf("v%0d audio_out", i),    32'(audio_out),    32'(vq[i].aud));
         chk($sformatf("v%0d sample_valid", i), 32'(sample_valid), 32'(vq[i].sv));
         chk($sformatf("v%0d playing", i),      32'(playing),      32'(vq[i].pl));
         chk($sformatf("v%0d back_mode", i),    32'(back_mode),    32'(vq[i].bm));
         chk($sformatf("v%0d underrun", i),     32'(underrun),     32'(vq[i].ur));
         chk($sformatf("v%0d end_of_track", i), 32'(end_of_track), 32'(vq[i].eot));
      end

      // Asynchronous reset while a fetch is being issued.
      do_reset();
      key(K_PLAY); idle();
      chk("ar pre read_start", 32'(read_start), 32'd1);
      @(negedge clk); rst = 1'b1; #1;
      chk("ar read_start", 32'(read_start), 32'd0);
      chk("ar playing", 32'(playing), 32'd0);

      // Stop during WAIT_DATA completes the read, then pauses.
      do_reset();
      key(K_PLAY); idle();
      key(K_STOP); chk("sw playing held", 32'(playing), 32'd1);
      idle();      chk("sw still waiting", 32'(playing), 32'd1);
      rv(32'hCAFEBABE); chk("sw paused", 32'(playing), 32'd0);
      tk();        chk("sw tick no sample", 32'(sample_valid), 32'd0);
                   chk("sw tick no underrun", 32'(underrun), 32'd0);
      key(K_PLAY); idle();
      chk("sw refetch start", 32'(read_start), 32'd1);
      chk("sw refetch addr", 32'(read_addr), 32'd0);

      // Underrun, then stop mid-word and resume at the same sample.
      do_reset();
      key(K_PLAY); idle();
      tk();   chk("ur pulse", 32'(underrun), 32'd1);
              chk("ur no sample", 32'(sample_valid), 32'd0);
      idle(); chk("ur one cycle", 32'(underrun), 32'd0);
      rv(32'h12345678);
      tk();   chk("ur sample", 32'(audio_out), 32'h56);
              chk("ur sample valid", 32'(sample_valid), 32'd1);
      key(K_STOP); chk("rs paused", 32'(playing), 32'd0);
      key(K_PLAY); idle();
      chk("rs refetch addr", 32'(read_addr), 32'd0);
      chk("rs refetch start", 32'(read_start), 32'd1);
      rv(32'h12345678);
      tk();   chk("rs resumed lane", 32'(audio_out), 32'h12);
              chk("rs next addr", 32'(read_addr), 32'd1);

      // Restart mid-word while playing backward.
      do_reset();
      key(K_BACK); key(K_PLAY); idle();
      rv(32'hDEADBEEF);
      tk();   chk("rb first lane", 32'(audio_out), 32'hDE);
      key(K_RST);
      chk("rb addr end", 32'(read_addr), 32'd3);
      chk("rb playing", 32'(playing), 32'd1);
      idle(); chk("rb fetch", 32'(read_start), 32'd1);
      rv(32'hA1B2C3D4);
      tk();   chk("rb upper lane first", 32'(audio_out), 32'hA1);

      // Forward wrap at the last word of the track.
      do_reset();
      key(K_BACK); key(K_RST);
      chk("fw paused restart addr", 32'(read_addr), 32'd3);
      chk("fw paused", 32'(playing), 32'd0);
      key(K_FWD); chk("fw back_mode", 32'(back_mode), 32'd0);
      key(K_PLAY); idle();
      chk("fw fetch addr", 32'(read_addr), 32'd3);
      rv(32'h01020304);
      tk();   chk("fw lane0", 32'(audio_out), 32'h03);
      tk();   chk("fw lane1", 32'(audio_out), 32'h01);
              chk("fw eot", 32'(end_of_track), 32'd1);
              chk("fw wrap addr", 32'(read_addr), 32'd0);
              chk("fw playing", 32'(playing), 32'(LOOP));
      idle(); chk("fw eot one cycle", 32'(end_of_track), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
      $finish;
   end

endmodule

// File: doc/audio_stream_ctrl.md
Name: audio_stream_ctrl

Overview:
Parametrised playback controller for the iPod audio path. It owns the flash word address and fetches words from the memory reader with a start/valid handshake. It splits each word into LANES samples and emits one sample per sample-rate tick, in forward or reverse order. Keyboard commands give play/stop/direction/restart control. An underrun flag and an end-of-track flag are provided.

Parameters:
DATA_W, 32, memory word width
LANE_W, 16, width of one sample lane in a word; LANES = DATA_W/LANE_W (integer ≥1)
OUT_W, 8, audio output width; taken from the top OUT_W bits of a lane (OUT_W ≤ LANE_W)
ADDR_W, 23, word address width
ADDR_START, 0, first word of track
ADDR_END, 23'h7FFFF, last word of track (ADDR_END ≥ ADDR_START)
KEY_PLAY, 8'h24, play key code (E)
KEY_STOP, 8'h23, stop key code (D)
KEY_FWD, 8'h2B, forward key code (F)
KEY_BACK, 8'h32, backward key code (B)
KEY_RESTART, 8'h2D, restart key code (R)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
kbd_data  in  8  key code; all inputs synchronous to clk
kbd_ready  in  1  kbd_data valid this cycle; keys ignored when low
tick  in  1  one-cycle sample-rate strobe
read_start  out  1  one-cycle fetch request for read_addr
read_addr  out  ADDR_W  word address being fetched
read_valid  in  1  one-cycle strobe; read_data valid
read_data  in  DATA_W  fetched word
audio_out  out  OUT_W  current sample, held between updates
sample_valid  out  1  one-cycle pulse: audio_out updated this cycle
playing  out  1  high in any state except PAUSE
back_mode  out  1  0 forward, 1 backward
underrun  out  1  one-cycle pulse: tick arrived while FETCH/WAIT_DATA
end_of_track  out  1  one-cycle pulse on passing the track boundary

Behaviour:
- Reset: state PAUSE, read_addr=ADDR_START, lane index 0, back_mode=0, all pulse outputs 0, audio_out=0, word buffer 0.
- States:
  - PAUSE: play key goes to FETCH.
  - FETCH: read_start=1 for exactly one cycle, then WAIT_DATA.
  - WAIT_DATA: read_valid latches read_data into the word buffer, then WAIT_TICK.
  - WAIT_TICK: waits for tick.
- Emit, in WAIT_TICK with tick: audio_out <= buffer[lane*LANE_W+LANE_W-1 -: OUT_W] and sample_valid=1 on the next cycle (1-cycle latency).
  - Not last lane: the lane advances and the block stays in WAIT_TICK.
  - Last lane: the address advances and the block goes to FETCH.
- Lane order: forward is 0→LANES-1, backward is LANES-1→0. The first lane of a word is set when the word is latched.
- Address: forward increments, backward decrements.
  - Forward wrap: ADDR_END → ADDR_START.
  - Backward wrap: ADDR_START → ADDR_END.
  - end_of_track pulses in the cycle the wrap is committed.
- Direction keys update back_mode immediately. Lane order and address step use the back_mode value in effect when the word is latched or advanced. A word in progress keeps its latched order.
- Stop key:
  - In WAIT_TICK or FETCH (before read_start issued), goes to PAUSE. Address, lane and buffer are kept, so play resumes at the same sample. Resume always refetches the word.
  - In WAIT_DATA, the stop is recorded. The block waits for read_valid, latches the word, then goes to PAUSE with no dangling handshake.
- Restart key: lane is set to 0, and read_addr is set to ADDR_START (forward) or ADDR_END (backward).
  - If playing, go to FETCH. WAIT_DATA first completes the outstanding read and discards its data.
  - If paused, stay in PAUSE.
- Priority within one cycle: stop > restart > play. Direction keys are independent of the state keys.
- A tick outside WAIT_TICK is dropped, and underrun pulses if the state is FETCH or WAIT_DATA. A tick in PAUSE is ignored silently.
- read_valid outside WAIT_DATA is ignored.
- Asserting rst at any point returns every output to its reset value immediately.

Optional Feature:
AUDIO_STREAM_LOOP_EN.
- Defined: on wrap, the address wraps, end_of_track pulses, and playback continues (FETCH).
- Undefined: on wrap, end_of_track pulses, the address is set to the wrap target, lane is set to 0, and the state goes to PAUSE (single-shot play).

Test Plan:
- Reset → play key (8'h24), read_data=32'hAABB_CCDD → read_start with read_addr=0; ticks give audio_out 8'hCC, then 8'hAA, each with a single-cycle sample_valid; next read_start has read_addr=1.
- Back key (8'h32) before latch, read_data=32'h1122_3344 → audio_out 8'h11, then 8'h33; next read_addr decrements; from addr 0 it wraps to ADDR_END with end_of_track=1.
- Stop key during WAIT_DATA → state stays until read_valid, then PAUSE; playing=0; ticks produce no sample_valid; play refetches the same address.
- Tick during WAIT_DATA → underrun pulses once; no sample_valid; next tick in WAIT_TICK emits normally.
- Forward at read_addr=ADDR_END, last lane → LOOP_EN: read_addr=ADDR_START, end_of_track=1, playback continues; without the macro: PAUSE, read_addr=ADDR_START.
- Restart key (8'h2D) mid-word while backward → read_addr=ADDR_END, lane LANES-1 first, FETCH issued.
